// File: rtl/probe_led_scanner.sv
// probe_led_scanner: N-channel probe capture and 7-seg scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module probe_led_scanner #(
  parameter int NUM_CH      = 8,
  parameter int SEL_W       = 3,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 10000
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [NUM_CH*32-1:0] probe_bus,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 page,
  input  logic                 hold,
  output logic [DIGITS-1:0]    LEDSEL,
  output logic [7:0]           LEDOUT,
  output logic                 frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WW = DIGITS * 4;
  localparam int SH = (DIGITS == 8) ? 0 : WW;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0] prescale;
  logic [IW-1:0] idx;
  logic [31:0]   shadow;
  logic          page_q;
  logic          tick;
  logic          frame_end;
  logic [31:0]   sel_word;
  logic [WW-1:0] window;
  logic [IW-1:0] nib_idx;
  logic [3:0]    nib;
  logic [7:0]    seg;
  logic          blank;

  function automatic logic [7:0] encode(input logic [3:0] n);
    logic [7:0] s;
    s = 8'hFF;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick      = (prescale == P_LAST);
  assign frame_end = tick && (idx == I_LAST);

  // Page is latched with the frame so the window never tears.
  assign window  = WW'(shadow >> (page_q ? SH : 0));
  assign nib_idx = I_LAST - idx;
  assign nib     = window[{nib_idx, 2'b00} +: 4];
  assign seg     = encode(nib);

  // Selected probe word; out-of-range channels read as zero.
  always_comb begin
    sel_word = '0;
    if (32'(sel) < NUM_CH)
      sel_word = probe_bus[32'(sel)*32 +: 32];
  end

  // Blank digit when it and all higher nibbles are zero.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != I_LAST) &&
            ((window >> {nib_idx, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
  end

  // Prescaler and digit index walk the scan.
  always_ff @(posedge Clk) begin
    if (reset) begin
      prescale <= '0;
      idx      <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick)
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Frame-boundary capture of the probe word and page.
  always_ff @(posedge Clk) begin
    if (reset) begin
      shadow <= '0;
      page_q <= 1'b0;
    end else if (frame_end) begin
      page_q <= page;
      if (!hold)
        shadow <= sel_word;
    end
  end

  // Registered display outputs, one cycle behind idx.
  always_ff @(posedge Clk) begin
    if (reset) begin
      LEDSEL     <= '1;
      LEDOUT     <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      LEDSEL     <= ~(DIGITS'(1) << idx);
      LEDOUT     <= blank ? 8'hFF : seg;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_probe_led_scanner.sv
// tb_probe_led_scanner: scoreboard bench, two scanner configs.
// Model predicts each output cycle from frame arithmetic.
module tb_probe_led_scanner;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NCH*32-1:0]  probe_bus;
  logic [2:0]         sel;
  logic               page;
  logic               hold;
  logic [31:0]        ch [NCH];

  logic [7:0] ledsel_a, ledout_a;
  logic       ft_a;
  logic [3:0] ledsel_b;
  logic [7:0] ledout_b;
  logic       ft_b;

  for (genvar g = 0; g < NCH; g++) begin : g_bus
    assign probe_bus[g*32 +: 32] = ch[g];
  end

  probe_led_scanner #(
    .NUM_CH(NCH), .SEL_W(3), .DIGITS(8), .REFRESH_DIV(4)
  ) u_a (
    .Clk(clk), .reset(reset), .probe_bus(probe_bus),
    .sel(sel), .page(page), .hold(hold),
    .LEDSEL(ledsel_a), .LEDOUT(ledout_a), .frame_tick(ft_a)
  );

  probe_led_scanner #(
    .NUM_CH(NCH), .SEL_W(3), .DIGITS(4), .REFRESH_DIV(3)
  ) u_b (
    .Clk(clk), .reset(reset), .probe_bus(probe_bus),
    .sel(sel), .page(page), .hold(hold),
    .LEDSEL(ledsel_b), .LEDOUT(ledout_b), .frame_tick(ft_b)
  );

  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int checks = 0;
  int errors = 0;
  logic [16:0] q_a [$];
  logic [16:0] q_b [$];

  int          k_a, k_b;
  logic [31:0] sh_a, sh_b;
  logic        pg_a, pg_b;

  // Output after the k-th edge since reset release.
  function automatic logic [16:0] predict(
    input int D, input int R, input int k,
    input logic [31:0] sh, input logic pg);
    int d;
    logic [31:0] win, rest;
    logic [7:0] lsel, lout;
    logic ft;
    d = ((k - 1) / R) % D;
    if (D == 8) win = sh;
    else win = (sh >> (pg ? D*4 : 0)) & ((32'h1 << (D*4)) - 1);
    rest = win >> ((D - 1 - d) * 4);
    lout = SEG[rest[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
    if (d != D - 1 && rest == 0) lout = 8'hFF;
`endif
    lsel = ~(8'h01 << d);
    ft = ((k % (D * R)) == 0);
    return {lsel, lout, ft};
  endfunction

  function automatic logic [31:0] chword();
    int s;
    s = int'(sel);
    return (s < NCH) ? ch[s] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom & 32'hFF;
      2: return 32'h0;
      3: return $urandom & 32'h000FF000;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  // Reference model: pushes the expected response of every edge.
  always @(posedge clk) begin
    if (reset) begin
      q_a.push_back({8'hFF, 8'hFF, 1'b0});
      q_b.push_back({8'hFF, 8'hFF, 1'b0});
      k_a = 0; sh_a = 0; pg_a = 0;
      k_b = 0; sh_b = 0; pg_b = 0;
    end else begin
      k_a++;
      k_b++;
      q_a.push_back(predict(8, 4, k_a, sh_a, pg_a));
      q_b.push_back(predict(4, 3, k_b, sh_b, pg_b));
      if (k_a % 32 == 0) begin
        pg_a = page;
        if (!hold) sh_a = chword();
      end
      if (k_b % 12 == 0) begin
        pg_b = page;
        if (!hold) sh_b = chword();
      end
    end
  end

  // Monitor: pops and compares away from the clock edge.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    checks++;
    if (q_a.size() == 0) begin
      errors++;
      $display("FAIL scan8 no expected entry");
    end else begin
      e = q_a.pop_front();
      if ({ledsel_a, ledout_a, ft_a} !== e) begin
        errors++;
        $display("FAIL scan8 t=%0t got sel=%h seg=%h ft=%b want sel=%h seg=%h ft=%b",
                 $time, ledsel_a, ledout_a, ft_a, e[16:9], e[8:1], e[0]);
      end
    end
    checks++;
    if (q_b.size() == 0) begin
      errors++;
      $display("FAIL scan4 no expected entry");
    end else begin
      e = q_b.pop_front();
      if ({4'hF, ledsel_b, ledout_b, ft_b} !== e) begin
        errors++;
        $display("FAIL scan4 t=%0t got sel=%h seg=%h ft=%b want sel=%h seg=%h ft=%b",
                 $time, ledsel_b, ledout_b, ft_b, e[12:9], e[8:1], e[0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    sel   = 3'd2;
    page  = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < NCH; i++) ch[i] = 32'h0;
    ch[2] = 32'h1234ABCD;
    ch[1] = 32'h000000A5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    hold  = 1'b1;
    ch[2] = 32'hFFFFFFFF;
    repeat (100) @(negedge clk);
    hold = 1'b0;
    repeat (70) @(negedge clk);
    sel = 3'd5;
    repeat (70) @(negedge clk);
    sel = 3'd2;
    repeat (45) @(negedge clk);
    sel = 3'd1;
    repeat (70) @(negedge clk);
    ch[2] = 32'h1234ABCD;
    sel   = 3'd2;
    page  = 1'b1;
    repeat (70) @(negedge clk);
    page = 1'b0;
    repeat (70) @(negedge clk);
    ch[1] = 32'h0;
    sel   = 3'd1;
    repeat (70) @(negedge clk);
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if (it == 700 || it == 701) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 39) == 0) sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) page = ~page;
      if ($urandom_range(0, 49) == 0) hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0)
        ch[$urandom_range(0, NCH-1)] = rand_word();
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
